uart_word_arbiter: RTL
======================

# uart_word_arbiter

Round-robin arbiter that shares the single 64-bit-word UART transmitter among `NUM_REQ` requesters, such as PUF response generators and a status reporter. It accepts one word from the winning requester and holds it in a register. It presents the word to the transmitter over a valid/ready handshake, then tracks the transmitter's busy/done cycle before granting again. The block sits between the PUF sources and the UART TX word serializer.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: width of the grant index.
- `BUSY_WAIT`, default 4: maximum number of cycles in WAIT_BUSY before `tx_ready` is treated as never having dropped.
- `CNT_WIDTH`, default 16: width of the sent-word counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_data`  in  `NUM_REQ*64`: requester words; requester i uses bits [64i+63:64i].
- `req_valid`  in  `NUM_REQ`: a word is pending for requester i.
- `req_ready`  out  `NUM_REQ`: one-hot acceptance. A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_data`  out  64: word to the transmitter; byte 0 is sent first.
- `tx_valid`  out  1: the word is presented.
- `tx_ready`  in  1: transmitter idle. It falls one cycle after acceptance and rises when the last byte finishes.
- `grant_id`  out  `ID_WIDTH`: index of the requester whose word is in flight.
- `busy`  out  1: high whenever the state is not IDLE.
- `word_count`  out  `CNT_WIDTH`: number of completed words; wraps.

## Operation
States:
- **IDLE**
  - The winner is the first i with `req_valid[i]` set, searching from `(last+1) mod NUM_REQ` upward.
  - `req_ready[winner]` = 1 combinationally, in the same cycle.
  - On the transfer, latch the data into `hold_reg` and the index into `grant_id`, then go to PRESENT.
  - With no valid request, stay in IDLE.
- **PRESENT**
  - `tx_valid` = 1 and `tx_data` = `hold_reg`.
  - When `tx_ready` = 1, go to WAIT_BUSY. `tx_valid` is low from the next cycle.
- **WAIT_BUSY**
  - When `tx_ready` = 0, go to WAIT_DONE.
  - If `tx_ready` stays 1 for `BUSY_WAIT` cycles, go to IDLE and complete the word as below.
- **WAIT_DONE**
  - When `tx_ready` = 1, go to IDLE.
  - Set `last` = `grant_id` and increment `word_count`.

Rules:
- `req_ready` is 0 in every state except IDLE. At most one bit of `req_ready` is set.
- Requesters must hold `req_data` stable while `req_valid` is high and no transfer has occurred.
- The pointer `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- `word_count` wraps from all-ones to 0 with no flag.

## Timing
- Reset values:
  - State is IDLE.
  - `tx_valid` = 0, `tx_data` = 0, `grant_id` = 0.
  - `busy` = 0, `word_count` = 0, `req_ready` = 0 (the combinational path is gated while `rst` is high).
- Latency from a request transfer to `tx_valid` rising is 1 cycle.
- After acceptance by the transmitter, the next grant comes no earlier than the cycle after `tx_ready` rises in WAIT_DONE. The IDLE state lasts at least 1 cycle.
- Simultaneous requests are resolved by round-robin order only. A requester that keeps `req_valid` high cannot win twice in a row while another requester is valid.
- A requester that drops `req_valid` before its transfer loses nothing; the word is simply not taken.
- Reset mid-word: the state returns to IDLE and `hold_reg` is discarded. The transmitter has its own reset.
- `tx_ready` low while the state is PRESENT: hold `tx_valid` high indefinitely.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - `tx_data[63:56]` = `grant_id` zero-extended to 8 bits.
  - `tx_data[55:0]` = `req_data` bits [55:0] of the winner. The requester's upper byte is ignored.
- Not defined: all 64 bits pass through unchanged.

## Structure
- Shared package `uart_arb_pkg`:
  - state enum (IDLE, PRESENT, WAIT_BUSY, WAIT_DONE);
  - `WORD_W` = 64;
  - `TAG_W` = 8.
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs (`req_valid`, `last`) and outputs (`onehot`, `index`, `any`). It is instantiated once.

## Test plan
- Reset, then `req_valid` = 4'b0001 with data `64'h0123456789ABCDEF`:
  - `req_ready[0]` is high in the same cycle;
  - `tx_valid` is high 1 cycle later with that data;
  - a model transmitter drops `tx_ready` for 90 cycles;
  - `word_count` = 1 and the state returns to IDLE.
- All four requesters held valid for 8 words -> grant order is 0,1,2,3,0,1,2,3 and `word_count` = 8.
- `req_valid[2]` held continuously, with `req_valid[1]` asserted mid-word -> the next grant goes to 1, then to 2.
- Transmitter that never drops `tx_ready` -> the block returns to IDLE after `BUSY_WAIT` = 4 cycles of WAIT_BUSY and `word_count` increments.
- `rst` pulsed while in WAIT_DONE -> all outputs reach their reset values on the next cycle, and the first grant after reset goes to requester 0.
- With `UART_ARB_TAG_EN` defined, requester 3 sends `64'hFFFF_FFFF_FFFF_FFFF` -> `tx_data` = `64'h03FF_FFFF_FFFF_FFFF`.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART word arbiter slice.
package uart_arb_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned TAG_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_word_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid requester
// searching upward from (last+1) mod NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]  onehot,
  output logic [ID_WIDTH-1:0] index,
  output logic                any
);

  int unsigned         cand;
  logic [ID_WIDTH-1:0] cidx;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    cidx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last) + k) % NUM_REQ;
      cidx = ID_WIDTH'(cand);
      if (!any && req_valid[cidx]) begin
        any          = 1'b1;
        onehot[cidx] = 1'b1;
        index        = cidx;
      end
    end
  end

endmodule

// File: rtl/uart_word_arbiter.sv
// Round-robin arbiter feeding one 64-bit word UART transmitter.
// Optional macro UART_ARB_TAG_EN: top byte of tx_data carries grant_id.
module uart_word_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ),
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [WORD_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        word_count
);

  localparam int unsigned BW_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  arb_state_e          state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [BW_W-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_WIDTH-1:0] pick_index;
  logic                pick_any;
  logic [WORD_W-1:0]   pick_word;
  logic                complete;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .req_valid(req_valid),
    .last     (last_q),
    .onehot   (pick_onehot),
    .index    (pick_index),
    .any      (pick_any)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_word = req_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    word_count_d = word_count_q;
    complete     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
`ifdef UART_ARB_TAG_EN
          hold_d = {TAG_W'(pick_index), pick_word[WORD_W-TAG_W-1:0]};
`else
          hold_d = pick_word;
`endif
          grant_d = pick_index;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (tx_ready) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never drops ready still completes the word
        if (!tx_ready)                           state_d  = WAIT_DONE;
        else if (cnt_q == BW_W'(BUSY_WAIT - 1)) complete = 1'b1;
        else                                     cnt_d    = cnt_q + 1'b1;
      end
      WAIT_DONE: begin
        if (tx_ready) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      state_d      = IDLE;
      last_d       = grant_q;
      word_count_d = word_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      grant_q      <= '0;
      last_q       <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign req_ready  = (state_q == IDLE && !rst) ? pick_onehot : '0;
  assign tx_valid   = (state_q == PRESENT);
  assign tx_data    = hold_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

endmodule
